ts4231_configurator: RTL and testbench

- Drives the TS4231 E/D pins *into* the sensor, the opposite direction to normal pulse reception: writes a 15-bit configuration word, reads it back, verifies it, then puts the sensor in watch mode.
- One instance per sensor channel sits between the FPGA pads (tristate split in the top level) and the pulse-decoding core.
- Runs once after power-up, or on request. When finished it releases both pins so the receive path owns them.

---
 rtl/ts4231_pkg.sv | 78 +++++++
 rtl/ts4231_configurator_tick_gen.sv | 27 ++
 rtl/ts4231_configurator.sv | 171 +++++++++++++++++
 tb/tb_ts4231_configurator.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ts4231_pkg.sv
// Shared types and constants for the TS4231 configuration sequencer.
// pin_pattern() is the single place that knows what E/D look like in each phase.
package ts4231_pkg;

  localparam int TS4231_WORD_WIDTH = 15;
  localparam logic [TS4231_WORD_WIDTH-1:0] TS4231_DEFAULT_CONFIG = 15'h392B;

  localparam logic [2:0] PH_A          = 3'd0;
  localparam logic [2:0] PH_B          = 3'd1;
  localparam logic [2:0] PH_C          = 3'd2;
  localparam logic [2:0] PH_CFG_LAST   = 3'd4;
  localparam logic [2:0] PH_WATCH_LAST = 3'd1;

  typedef enum logic [3:0] {
    IDLE, CFG_ENTRY, WR_START, WR_BIT, WR_STOP, RD_START,
    RD_BIT, RD_STOP, CHECK, WATCH, DONE, FAIL
  } ts4231_state_e;

  typedef struct packed {
    logic e_out;
    logic e_oe;
    logic d_out;
    logic d_oe;
  } ts4231_pins_t;

  function automatic logic [2:0] last_phase(input ts4231_state_e st);
    case (st)
      CFG_ENTRY: return PH_CFG_LAST;
      WATCH:     return PH_WATCH_LAST;
      default:   return PH_C;
    endcase
  endfunction

  // States whose phases are paced by the tick prescaler.
  function automatic logic is_timed(input ts4231_state_e st);
    return !(st inside {IDLE, CHECK, DONE, FAIL});
  endfunction

  function automatic ts4231_pins_t pin_pattern(input ts4231_state_e st,
                                               input logic [2:0] ph,
                                               input logic dbit);
    ts4231_pins_t p;
    p = '0;
    case (st)
      CFG_ENTRY: begin
        p.e_oe = 1'b1; p.d_oe = 1'b1;
        p.e_out = !(ph == 3'd2 || ph == 3'd3);
        p.d_out = (ph == 3'd0) || (ph >= 3'd3);
      end
      WR_START, RD_START: begin
        p.e_oe = 1'b1; p.d_oe = 1'b1;
        p.e_out = (ph != PH_C);
        p.d_out = (ph == PH_A);
      end
      WR_BIT: begin
        p.e_oe = 1'b1; p.d_oe = 1'b1;
        p.e_out = (ph == PH_B);
        p.d_out = dbit;
      end
      RD_BIT: begin
        p.e_oe = 1'b1;
        p.e_out = (ph == PH_B);
      end
      WR_STOP, RD_STOP: begin
        p.e_oe = 1'b1; p.d_oe = 1'b1;
        p.e_out = (ph != PH_A);
        p.d_out = (ph == PH_C);
      end
      WATCH: begin
        p.e_oe = 1'b1; p.d_oe = 1'b1;
        p.e_out = (ph == PH_A);
      end
      default: p = '0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/ts4231_configurator_tick_gen.sv
// Phase prescaler: counts 0..PERIOD-1 while enabled, held at 0 otherwise,
// and flags the last cycle of each phase.
module ts4231_tick_gen #(
  parameter int PERIOD = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);
  localparam int CW = $clog2(PERIOD);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!en || cnt == CW'(PERIOD - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = en && (cnt == CW'(PERIOD - 1));

endmodule

// File: rtl/ts4231_configurator.sv
// Writes a configuration word into a TS4231 over its E/D pins, reads it back,
// retries on mismatch, then enters watch mode and releases both pins.
module ts4231_configurator
  import ts4231_pkg::*;
#(
  parameter int HALF_PERIOD_CYCLES = 24,  // must be >= 4 so the D synchroniser settles inside phase B
  parameter int MAX_RETRIES        = 3,
  parameter int WORD_WIDTH         = TS4231_WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  io_start,
  input  logic [WORD_WIDTH-1:0] io_config_word,
  input  logic                  io_e_in,
  input  logic                  io_d_in,
  output logic                  io_e_out,
  output logic                  io_e_oe,
  output logic                  io_d_out,
  output logic                  io_d_oe,
  output logic                  io_busy,
  output logic                  io_done,
  output logic                  io_error,
  output logic [WORD_WIDTH-1:0] io_readback,
  output logic [1:0]            io_attempts,
  output ts4231_state_e         dbg_state,
  output logic                  dbg_e_sync
);
  localparam int BW = $clog2(WORD_WIDTH);

  ts4231_state_e         state;
  logic [2:0]            phase;
  logic [BW-1:0]         bit_idx;
  logic [WORD_WIDTH-1:0] word;
  logic [WORD_WIDTH-1:0] shift;
  ts4231_pins_t          pins;
  logic                  e_meta, e_sync, d_meta, d_sync;
  logic                  tick;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {e_meta, e_sync, d_meta, d_sync} <= '0;
    end else begin
      {e_meta, e_sync} <= {io_e_in, e_meta};
      {d_meta, d_sync} <= {io_d_in, d_meta};
    end
  end

  ts4231_tick_gen #(.PERIOD(HALF_PERIOD_CYCLES)) u_tick (
    .clk  (clk),
    .rst  (reset),
    .en   (is_timed(state)),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      phase       <= PH_A;
      bit_idx     <= '0;
      word        <= TS4231_DEFAULT_CONFIG;
      shift       <= '0;
      pins        <= '0;
      io_busy     <= 1'b0;
      io_done     <= 1'b0;
      io_error    <= 1'b0;
      io_readback <= '0;
      io_attempts <= '0;
    end else begin
      unique case (state)
        IDLE, DONE, FAIL: begin
          if (io_start) begin
            word        <= io_config_word;
            shift       <= '0;
            io_done     <= 1'b0;
            io_error    <= 1'b0;
            io_attempts <= '0;
            io_busy     <= 1'b1;
            state       <= CFG_ENTRY;
            phase       <= PH_A;
            pins        <= pin_pattern(CFG_ENTRY, PH_A, 1'b0);
          end
        end
        CHECK: begin
          io_readback <= shift;
          phase       <= PH_A;
          if (shift == word) begin
            state <= WATCH;
            pins  <= pin_pattern(WATCH, PH_A, 1'b0);
          end else if (int'(io_attempts) < MAX_RETRIES) begin
            io_attempts <= io_attempts + 2'd1;
            state       <= CFG_ENTRY;
            pins        <= pin_pattern(CFG_ENTRY, PH_A, 1'b0);
          end else begin
            state    <= FAIL;
            pins     <= '0;
            io_error <= 1'b1;
            io_busy  <= 1'b0;
          end
        end
        default: begin
          if (tick) begin
            // Last clk of phase B: the sensor has had a full half-phase to settle D.
            if (state == RD_BIT && phase == PH_B) begin
              shift <= {shift[WORD_WIDTH-2:0], d_sync};
            end
            if (phase != last_phase(state)) begin
              phase <= phase + 3'd1;
              pins  <= pin_pattern(state, phase + 3'd1, word[bit_idx]);
            end else begin
              phase <= PH_A;
              case (state)
                CFG_ENTRY: begin
                  state <= WR_START;
                  pins  <= pin_pattern(WR_START, PH_A, 1'b0);
                end
                WR_START: begin
                  state   <= WR_BIT;
                  bit_idx <= BW'(WORD_WIDTH - 1);
                  pins    <= pin_pattern(WR_BIT, PH_A, word[WORD_WIDTH-1]);
                end
                WR_BIT: begin
                  if (bit_idx == '0) begin
                    state <= WR_STOP;
                    pins  <= pin_pattern(WR_STOP, PH_A, 1'b0);
                  end else begin
                    bit_idx <= bit_idx - 1'b1;
                    pins    <= pin_pattern(WR_BIT, PH_A, word[bit_idx - 1'b1]);
                  end
                end
                WR_STOP: begin
                  state <= RD_START;
                  pins  <= pin_pattern(RD_START, PH_A, 1'b0);
                end
                RD_START: begin
                  state   <= RD_BIT;
                  bit_idx <= BW'(WORD_WIDTH - 1);
                  pins    <= pin_pattern(RD_BIT, PH_A, 1'b0);
                end
                RD_BIT: begin
                  if (bit_idx == '0) begin
                    state <= RD_STOP;
                    pins  <= pin_pattern(RD_STOP, PH_A, 1'b0);
                  end else begin
                    bit_idx <= bit_idx - 1'b1;
                    pins    <= pin_pattern(RD_BIT, PH_A, 1'b0);
                  end
                end
                RD_STOP: state <= CHECK;  // pins hold (1,1) through the compare cycle
                WATCH: begin
                  state   <= DONE;
                  pins    <= '0;
                  io_done <= 1'b1;
                  io_busy <= 1'b0;
                end
                default: state <= IDLE;
              endcase
            end
          end
        end
      endcase
    end
  end

  assign io_e_out   = pins.e_out;
  assign io_e_oe    = pins.e_oe;
  assign io_d_out   = pins.d_out;
  assign io_d_oe    = pins.d_oe;
  assign dbg_state  = state;
  assign dbg_e_sync = e_sync;

endmodule

// File: tb/tb_ts4231_configurator.sv
// Directed bench for ts4231_configurator with a small TS4231 readback model.
module tb_ts4231_configurator;
  import ts4231_pkg::*;

  localparam int HP = 4;
  localparam int W  = 15;
  // Latencies in clks from the cycle io_start is driven to the flag edge.
  localparam int LAT_ONE   = 109 * HP + 2;   // 107 ticks + CHECK + 2 WATCH ticks + start
  localparam int LAT_RETRY = 216 * HP + 3;   // two 107-tick passes, two CHECKs, WATCH
  localparam int LAT_FAIL  = 428 * HP + 5;   // four 107-tick passes, four CHECKs, FAIL entry
  localparam int RISE1_LAT = 4 * HP + 1;     // second E rise: CFG_ENTRY phase 4

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          io_start = 1'b0;
  logic [W-1:0]  io_config_word = '0;
  logic          io_e_in = 1'b0;
  logic          io_d_in = 1'b0;
  logic          io_e_out, io_e_oe, io_d_out, io_d_oe;
  logic          io_busy, io_done, io_error;
  logic [W-1:0]  io_readback;
  logic [1:0]    io_attempts;
  ts4231_state_e dbg_state;
  logic          dbg_e_sync;

  int           tests = 0;
  int           fails = 0;
  int           clk_cnt = 0;
  int           t0 = 0;
  int           lat = 0;
  int           rise_n = 0;
  int           rise1_lat = 0;
  int           rd_num = 0;
  int           rd_idx = 0;
  bit           rd_active = 0;
  bit           pend = 0;
  bit           prev_e = 0;
  bit           late_mode = 0;
  logic [W-1:0] cap = '0;
  logic [W-1:0] cur_resp = '0;
  logic [W-1:0] resp [4];

  ts4231_configurator #(.HALF_PERIOD_CYCLES(HP)) dut (
    .clk            (clk),
    .reset          (reset),
    .io_start       (io_start),
    .io_config_word (io_config_word),
    .io_e_in        (io_e_in),
    .io_d_in        (io_d_in),
    .io_e_out       (io_e_out),
    .io_e_oe        (io_e_oe),
    .io_d_out       (io_d_out),
    .io_d_oe        (io_d_oe),
    .io_busy        (io_busy),
    .io_done        (io_done),
    .io_error       (io_error),
    .io_readback    (io_readback),
    .io_attempts    (io_attempts),
    .dbg_state      (dbg_state),
    .dbg_e_sync     (dbg_e_sync)
  );

  // Clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) clk_cnt <= clk_cnt + 1;

  // Sensor model and written-bit capture, evaluated on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (io_e_out && !prev_e && io_d_oe) begin
        if (rise_n >= 2 && rise_n <= 16) cap = {cap[W-2:0], io_d_out};
        if (rise_n == 1) rise1_lat = clk_cnt - t0;
        rise_n++;
      end
      if (!io_d_oe && io_e_oe) begin
        if (!rd_active) begin
          rd_active = 1;
          rd_idx = W - 1;
          cur_resp = resp[(rd_num < 4) ? rd_num : 3];
          rd_num++;
        end
        if (pend && rd_idx >= 0) begin
          io_d_in = cur_resp[rd_idx];
          rd_idx--;
        end
        pend = 0;
        if (!late_mode && io_e_out && !prev_e) pend = 1;
        if (late_mode && !io_e_out && prev_e && rd_idx >= 0) begin
          io_d_in = cur_resp[rd_idx];
          rd_idx--;
        end
      end else begin
        rd_active = 0;
        pend = 0;
        io_d_in = 1'b0;
      end
      prev_e = io_e_out;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_start(input logic [W-1:0] w);
    @(negedge clk);
    io_config_word = w;
    io_start = 1'b1;
    t0 = clk_cnt;
    rise_n = 0;
    rd_num = 0;
    cap = '0;
    @(negedge clk);
    io_start = 1'b0;
  endtask

  task automatic wait_end(input int budget, output int l);
    int n;
    n = 0;
    while (!(io_done || io_error) && n < budget) begin
      @(negedge clk);
      n++;
    end
    l = clk_cnt - t0;
  endtask

  task automatic set_resp(input logic [W-1:0] a, input logic [W-1:0] b);
    resp[0] = a;
    resp[1] = b;
    resp[2] = b;
    resp[3] = b;
  endtask

  initial begin
    set_resp(15'h392B, 15'h392B);
    #12;
    check("rst_pins", {io_e_out, io_e_oe, io_d_out, io_d_oe}, 4'h0);
    check("rst_flags", {io_busy, io_done, io_error}, 3'h0);
    check("rst_readback", io_readback, 0);
    check("rst_attempts", io_attempts, 0);
    check("rst_state", dbg_state, IDLE);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Nominal single attempt
    run_start(15'h392B);
    check("nom_busy", io_busy, 1);
    wait_end(3000, lat);
    check("nom_latency", lat, LAT_ONE);
    check("nom_first_rise", rise1_lat, RISE1_LAT);
    check("nom_wr_bits", cap, 15'h392B);
    check("nom_flags", {io_busy, io_done, io_error}, 3'b010);
    check("nom_readback", io_readback, 15'h392B);
    check("nom_attempts", io_attempts, 0);
    check("nom_oe", {io_e_oe, io_d_oe}, 2'b00);
    check("nom_state", dbg_state, DONE);

    // Start while busy (inside WR_BIT) with a different word on the bus
    run_start(15'h392B);
    repeat (30 * HP) @(negedge clk);
    io_config_word = 15'h1234;
    io_start = 1'b1;
    @(negedge clk);
    io_start = 1'b0;
    check("busy_start_state", dbg_state, WR_BIT);
    wait_end(3000, lat);
    check("busy_start_latency", lat, LAT_ONE);
    check("busy_start_wr_bits", cap, 15'h392B);
    check("busy_start_readback", io_readback, 15'h392B);

    // Reset in the middle of RD_BIT
    run_start(15'h392B);
    repeat (70 * HP) @(negedge clk);
    check("mid_rd_state", dbg_state, RD_BIT);
    reset = 1'b1;
    #1;
    check("mid_rst_oe", {io_e_oe, io_d_oe}, 2'b00);
    check("mid_rst_busy", io_busy, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_start(15'h392B);
    wait_end(3000, lat);
    check("post_rst_latency", lat, LAT_ONE);
    check("post_rst_readback", io_readback, 15'h392B);

    // One readback mismatch then success
    set_resp(15'h392A, 15'h392B);
    run_start(15'h392B);
    wait_end(3000, lat);
    check("retry_latency", lat, LAT_RETRY);
    check("retry_flags", {io_done, io_error}, 2'b10);
    check("retry_attempts", io_attempts, 1);
    check("retry_readback", io_readback, 15'h392B);

    // Persistent mismatch
    set_resp(15'h0000, 15'h0000);
    run_start(15'h392B);
    wait_end(4000, lat);
    check("fail_latency", lat, LAT_FAIL);
    check("fail_flags", {io_busy, io_done, io_error}, 3'b001);
    check("fail_attempts", io_attempts, 3);
    check("fail_readback", io_readback, 0);
    check("fail_oe", {io_e_oe, io_d_oe}, 2'b00);
    check("fail_state", dbg_state, FAIL);

    // Sensor changes D on the E fall: each sample sees the previous bit
    late_mode = 1;
    set_resp(15'h392B, 15'h392B);
    run_start(15'h392B);
    wait_end(4000, lat);
    check("late_latency", lat, LAT_FAIL);
    check("late_readback", io_readback, 15'h1C95);
    check("late_error", io_error, 1);
    late_mode = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
